// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared types and constants for the hazard scoreboard. Holds
//               the shadow-pipeline slot record, the register-zero tag and the
//               default parameter values used by the top and its counter.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Architectural register 0 is hard-wired; it is never a live write tag.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULDIV_LAT_DEFAULT = 32;
  localparam int CNT_W_DEFAULT      = 6;

  // One shadow-pipeline slot: destination tag, write enable, load flag.
  typedef struct packed {
    logic [4:0] wa;
    logic       we;
    logic       load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{wa: REG_ZERO, we: 1'b0, load: 1'b0};

  // Tag presented to the forwarding muxes: zero unless the slot writes.
  function automatic logic [4:0] live_tag(input slot_t s);
    return s.we ? s.wa : REG_ZERO;
  endfunction

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_muldiv_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_busy_ctr
// Description : Busy countdown for the HI/LO multiply/divide unit. Loads
//               MULDIV_LAT when a mult/div issues, otherwise counts down to
//               zero. Runs independently of pipeline freezes.
// Ports       : clk   - core clock, rising edge
//               rst_n - asynchronous active-low reset
//               load  - a mult/div issues this cycle
//               busy  - counter is nonzero
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_busy_ctr #(
  parameter int CNT_W      = 6,
  parameter int MULDIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_load_val = CNT_W'(MULDIV_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load and decrement never coincide: a new mult/div cannot issue while
  // the counter is nonzero because the ID stage is stalled on it.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = c_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule : muldiv_busy_ctr
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Producer-side partner of the operand forwarding muxes. Shadows
//               destination tags through EX/MEM/WB, publishes them as the
//               ra_* tag buses, and raises stall/bubble controls for hazards
//               forwarding cannot cover (load-use, HI/LO mult/div busy).
// Ports       : clk, rst_n           - clock, async active-low reset
//               id_*                 - decoded fields of the ID instruction
//               flush                - redirect, kills the ID instruction
//               mem_stall            - data-memory wait, freezes the pipeline
//               stall_id, bubble_ex  - pipeline controls to IF/ID/EX
//               ra_ex/ra_mem/ra_wb   - live write tags (0 when no write)
//               ex_is_load           - EX slot holds a load
//               muldiv_busy          - mult/div unit busy
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_wa,
  input  logic       id_we,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       id_reads_hilo,
  input  logic       flush,
  input  logic       mem_stall,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic [4:0] ra_ex,
  output logic [4:0] ra_mem,
  output logic [4:0] ra_wb,
  output logic       ex_is_load,
  output logic       muldiv_busy
);

  slot_t ex_q,  ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  logic load_use;
  logic md_haz;
  logic issue;
  logic md_issue;
  logic busy;

  // Only a load still in EX is unforwardable; from MEM onward the data is
  // on the bypass network, so MEM/WB loads never stall.
  assign load_use = id_valid & ex_q.we & ex_q.load & (ex_q.wa != REG_ZERO) &
                    ((id_uses_rs & (id_rs == ex_q.wa)) |
                     (id_uses_rt & (id_rt == ex_q.wa)));

  assign md_haz   = id_valid & (id_is_muldiv | id_reads_hilo) & busy;

  assign stall_id  = load_use | md_haz | mem_stall;
  // While memory is stalled the slots hold, so no bubble is needed; a flush
  // arriving then is held by the branch unit until the stall drops.
  assign bubble_ex = (load_use | md_haz | flush) & ~mem_stall;

  assign issue    = id_valid & ~stall_id & ~flush;
  assign md_issue = issue & id_is_muldiv;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble_ex || !id_valid) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d = '{wa: id_wa, we: id_we, load: id_is_load};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  muldiv_busy_ctr #(
    .CNT_W      (CNT_W),
    .MULDIV_LAT (MULDIV_LAT)
  ) u_busy_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (md_issue),
    .busy  (busy)
  );

  assign ra_ex       = live_tag(ex_q);
  assign ra_mem      = live_tag(mem_q);
  assign ra_wb       = live_tag(wb_q);
  assign ex_is_load  = ex_q.load;
  assign muldiv_busy = busy;

  // The WB load flag has no consumer; it is kept so every slot has the
  // same record shape.
  logic unused_wb_load;
  assign unused_wb_load = wb_q.load;

endmodule : hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side partner of the operand forwarding muxes.
- Tracks destination-register tags through a shadow EX/MEM/WB pipeline and drives the ra_ex/ra_mem/ra_wb tag buses those muxes compare against.
- Detects the hazards that forwarding cannot resolve (load-use, HI/LO multiply/divide busy) and issues stall/bubble controls to IF/ID/EX.
- Sits beside the ID stage of the 5-stage MIPS core.

Parameters:
- MULDIV_LAT, 32, cycles the mult/div unit is busy after a mult/div issues; legal range 1..2^CNT_W-1.
- CNT_W, 6, width of the busy counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a live instruction
- id_rs  in  5  source register A
- id_rt  in  5  source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_wa  in  5  destination register
- id_we  in  1  instruction writes the register file
- id_is_load  in  1  instruction is a load (LW/LB/...)
- id_is_muldiv  in  1  MULT/MULTU/DIV/DIVU
- id_reads_hilo  in  1  MFHI/MFLO
- flush  in  1  branch/jump redirect; kills the ID instruction
- mem_stall  in  1  data-memory wait; freezes the whole pipeline
- stall_id  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- ra_ex  out  5  EX-stage write tag; 0 if no write
- ra_mem  out  5  MEM-stage write tag; 0 if no write
- ra_wb  out  5  WB-stage write tag; 0 if no write
- ex_is_load  out  1  EX slot holds a load
- muldiv_busy  out  1  busy counter nonzero

Behaviour:
- Reset (async, rst_n=0):
  - All shadow slots cleared (tag=0, we=0, load=0).
  - Busy counter = 0.
  - All outputs 0.
  - Reset mid-operation discards in-flight tags and any mult/div countdown.
- Shadow slot contents: {wa, we, load} for EX, MEM and WB.
- Tag outputs: ra_x = we_x ? wa_x : 0.
  - Register 0 is never reported as a live tag, even when we_x=1 and wa_x=0.
- Combinational hazard terms:
  - load_use = id_valid & ex.we & ex.load & ex.wa!=0 & ((id_uses_rs & id_rs==ex.wa) | (id_uses_rt & id_rt==ex.wa)).
  - md_haz = id_valid & (id_is_muldiv | id_reads_hilo) & (cnt!=0).
- Output equations:
  - stall_id = load_use | md_haz | mem_stall.
  - bubble_ex = (load_use | md_haz | flush) & ~mem_stall.
- Load data is forwardable from the MEM stage, so a load in MEM or WB causes no stall. Exactly one bubble per load-use pair.
- Clock edge with mem_stall=1:
  - EX/MEM/WB slots hold.
  - Busy counter still decrements, because the divider is independent of the pipeline.
- Clock edge with mem_stall=0:
  - WB<=MEM and MEM<=EX.
  - EX <= zero if (bubble_ex | ~id_valid), else {id_wa, id_we, id_is_load}.
- Issue condition: id_valid & ~stall_id & ~flush.
- Busy counter:
  - Loads MULDIV_LAT when a mult/div issues.
  - Otherwise decrements when nonzero.
  - Issue while nonzero is impossible because md_haz stalls it, so load and decrement never collide.
- flush together with load_use: bubble_ex=1, stall_id=1. The redirect wins in the fetch logic, and the killed instruction never reaches EX.
- flush together with mem_stall: no bubble this cycle. The flush must be held by the branch unit until mem_stall drops.
- Latency: hazard outputs are purely combinational from ID and slot state. Tags move one stage per unstalled clock.

Decomposition:
- Shared package:
  - Slot record typedef {wa[4:0], we, load}.
  - REG_ZERO = 5'd0.
  - Default MULDIV_LAT.
- One natural sub-module: muldiv_busy_ctr (load/decrement counter with nonzero flag).
- The shadow pipeline and hazard logic stay in the top module.

Test Plan:
- Load-use: LW r5 in EX; ID ADD r6,r5,r7 (uses_rs, rs=5) -> stall_id=1 and bubble_ex=1 for exactly one cycle; next cycle ra_mem=5, ra_ex=6 after the ADD issues.
- Load then independent: LW r5 in EX; ID uses r8/r9 -> stall_id=0; tags advance so ra_ex=r8-writer's wa, ra_mem=5.
- Zero register: LW r0 in EX; ID reads r0 -> no stall; ra_ex=0 throughout.
- Mult/div busy: MULT issues at cycle t (MULDIV_LAT=4); MFLO in ID at t+1 -> stalls t+1..t+4, issues at t+5; muldiv_busy high t+1..t+4.
- mem_stall freeze: tags EX=3, MEM=4, WB=7; mem_stall=1 for 3 cycles -> tags unchanged, bubble_ex=0, stall_id=1, busy counter still decrements.
- Async reset mid-stream: assert rst_n=0 between edges during a load-use stall with cnt=10 -> all tags, stall_id and muldiv_busy drop to 0 immediately; after release, an MFHI issues with no stall.
